// File: rtl/fir_dma_pkg.sv
// fir_dma_pkg
//   Shared definitions for the fir_stream_dma loader/unloader:
//   - default address/data widths for the shared sample memory
//   - job sequencer state encoding
//   - read-issue credit helper used when draining results into the skid
package fir_dma_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 8;

  // Job sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_START  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_UNLOAD = 3'd4,
    ST_DRAIN  = 3'd5
  } dma_state_e;

  // A memory read may be launched only when every result it could produce
  // still has a guaranteed slot: stored skid entries plus the read already
  // in flight must leave room in the 2-entry skid.
  function automatic logic read_credit_ok(input logic [1:0] occ,
                                          input logic       pend);
    return ({1'b0, occ} + {2'b00, pend}) < 3'd2;
  endfunction

endpackage

// File: rtl/fir_dma_skid.sv
// fir_dma_skid
//   Two-entry fall-through output FIFO between the synchronous memory read
//   port and the m_valid/m_data stream.
//   When empty, a pushed word is presented on the output in the same cycle
//   (so read data reaches the stream with no extra register stage); if it is
//   not popped in that cycle it is stored and stays on the output unchanged.
//
//   Ports:
//     clk, rst     clock, asynchronous active-high reset
//     push         push_data is valid this cycle (read return)
//     push_data    read-return word
//     pop          consumer accepts out_data this cycle (valid && ready)
//     out_valid    a word is available on out_data
//     out_data     head word (zero when nothing is available)
//     occupancy    number of stored words (0..2), excludes a bypassing push
//
//   Handshake: a word is transferred when out_valid && pop. out_valid and
//   out_data never change while out_valid=1 and pop=0. The producer must
//   never push when occupancy==2 (enforced by the caller's read credit).
module fir_dma_skid #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic [DATA_W-1:0] entry_q [2];
  logic [DATA_W-1:0] entry_d [2];
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0]        occ_q, occ_d;

  logic              stored;
  logic              bypass;
  logic              do_store;
  logic              do_drop;

  always_comb begin
    entry_d   = entry_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    occ_d     = occ_q;

    stored    = (occ_q != 2'd0);
    out_valid = stored || push;
    if (stored) begin
      out_data = entry_q[rd_ptr_q];
    end else if (push) begin
      out_data = push_data;
    end else begin
      out_data = '0;
    end

    // An empty FIFO hands a push straight through when it is consumed at once.
    bypass   = push && pop && !stored;
    do_store = push && !bypass;
    do_drop  = pop && stored;

    if (do_store) begin
      entry_d[wr_ptr_q] = push_data;
      wr_ptr_d          = ~wr_ptr_q;
    end
    if (do_drop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    occ_d = occ_q + {1'b0, do_store} - {1'b0, do_drop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_q[0] <= '0;
      entry_q[1] <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      occ_q      <= 2'd0;
    end else begin
      entry_q[0] <= entry_d[0];
      entry_q[1] <= entry_d[1];
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      occ_q      <= occ_d;
    end
  end

  assign occupancy = occ_q;

endmodule

// File: rtl/fir_stream_dma.sv
// fir_stream_dma
//   Hardware loader/unloader for fir_top's shared sample memory (port A).
//   A job streams cfg_count samples from s_* into mem[cfg_in_addr + k],
//   pulses fir_start, waits for a fresh fir_done, then reads
//   mem[cfg_out_addr + j] back out on m_*. Samples are moved bit-exact.
//
//   Ports:
//     clk, rst               clock, asynchronous active-high reset
//     go                     start a job (sampled only while idle)
//     cfg_in_addr            base address for loaded samples
//     cfg_out_addr           base address of filter results
//     cfg_count              samples per job (0 is rejected with err)
//     s_valid/s_data/s_ready input sample stream
//     mem_addr/mem_we/mem_wdata/mem_rdata  memory port A, 1-cycle read
//     fir_start              one-cycle start pulse to the filter
//     fir_done               filter done level
//     m_valid/m_data/m_ready output sample stream
//     busy                   job in progress (state is not IDLE)
//     err                    one-cycle pulse on a rejected job
//
//   Handshake (both streams): a beat transfers on a cycle where valid and
//   ready are both high; valid never depends on ready, and a source holding
//   valid keeps its data stable until the beat transfers.
//   All addresses wrap modulo 2^ADDR_W.
module fir_stream_dma
  import fir_dma_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [ADDR_W-1:0] cfg_in_addr,
  input  logic [ADDR_W-1:0] cfg_out_addr,
  input  logic [ADDR_W-1:0] cfg_count,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              fir_start,
  input  logic              fir_done,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic              busy,
  output logic              err
);

  dma_state_e        state_q, state_d;
  logic [ADDR_W-1:0] in_base_q, in_base_d;
  logic [ADDR_W-1:0] out_base_q, out_base_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [ADDR_W-1:0] k_q, k_d;          // samples loaded so far
  logic [ADDR_W-1:0] j_q, j_d;          // result reads issued so far
  logic              seen_low_q, seen_low_d;
  logic              rd_pend_q, rd_pend_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] last_idx;
  logic              load_beat;
  logic              rd_issue;
  logic [1:0]        remaining;

  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic              skid_pop;
  logic [1:0]        skid_occ;

  assign last_idx  = count_q - ADDR_W'(1);
  assign load_beat = (state_q == ST_LOAD) && s_valid;
  assign rd_issue  = (state_q == ST_UNLOAD) && read_credit_ok(skid_occ, rd_pend_q);
  assign skid_pop  = skid_valid && m_ready;
  // Words still owed to the output stream: stored ones plus a read in flight.
  assign remaining = skid_occ + {1'b0, rd_pend_q};

  always_comb begin
    state_d    = state_q;
    in_base_d  = in_base_q;
    out_base_d = out_base_q;
    count_d    = count_q;
    k_d        = k_q;
    j_d        = j_q;
    seen_low_d = seen_low_q;
    rd_pend_d  = rd_issue;
    err_d      = 1'b0;

    s_ready    = 1'b0;
    mem_addr   = '0;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    fir_start  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (go) begin
          if (cfg_count == '0) begin
            err_d = 1'b1;
          end else begin
            in_base_d  = cfg_in_addr;
            out_base_d = cfg_out_addr;
            count_d    = cfg_count;
            k_d        = '0;
            j_d        = '0;
            state_d    = ST_LOAD;
          end
        end
      end

      ST_LOAD: begin
        s_ready   = 1'b1;
        mem_addr  = in_base_q + k_q;
        mem_wdata = s_data;
        mem_we    = load_beat;
        if (load_beat) begin
          k_d = k_q + ADDR_W'(1);
          if (k_q == last_idx) begin
            state_d = ST_START;
          end
        end
      end

      ST_START: begin
        fir_start  = 1'b1;
        // Start tracking done qualification afresh: a level still high from
        // the previous run must be seen dropping before it counts.
        seen_low_d = !fir_done;
        state_d    = ST_WAIT;
      end

      ST_WAIT: begin
        if (fir_done && seen_low_q) begin
          state_d = ST_UNLOAD;
        end else if (!fir_done) begin
          seen_low_d = 1'b1;
        end
      end

      ST_UNLOAD: begin
        mem_addr = out_base_q + j_q;
        if (rd_issue) begin
          j_d = j_q + ADDR_W'(1);
          if (j_q == last_idx) begin
            state_d = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        // Leave as soon as the final word is accepted (or nothing is owed).
        if ((remaining == 2'd0) || ((remaining == 2'd1) && skid_pop)) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      in_base_q  <= '0;
      out_base_q <= '0;
      count_q    <= '0;
      k_q        <= '0;
      j_q        <= '0;
      seen_low_q <= 1'b0;
      rd_pend_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_base_q  <= in_base_d;
      out_base_q <= out_base_d;
      count_q    <= count_d;
      k_q        <= k_d;
      j_q        <= j_d;
      seen_low_q <= seen_low_d;
      rd_pend_q  <= rd_pend_d;
      err_q      <= err_d;
    end
  end

  // Read data returns one cycle after issue; rd_pend_q marks that cycle.
  fir_dma_skid #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_pend_q),
    .push_data (mem_rdata),
    .pop       (skid_pop),
    .out_valid (skid_valid),
    .out_data  (skid_data),
    .occupancy (skid_occ)
  );

  assign m_valid = skid_valid;
  assign m_data  = skid_data;
  assign busy    = (state_q != ST_IDLE);
  assign err     = err_q;

endmodule

// File: tb/tb_fir_stream_dma.sv
// tb_fir_stream_dma
//   Bench for fir_stream_dma: memory model on port A, a filter-engine stand-in
//   that writes 2*x into the result region and raises done 20 cycles after
//   fir_start, an output scoreboard, and directed plus random jobs.
module tb_fir_stream_dma;

  localparam int AW = 10;
  localparam int DW = 8;

  // ---------------------------------------------------------------- signals
  logic          clk;
  logic          rst;
  logic          go;
  logic [AW-1:0] cfg_in_addr;
  logic [AW-1:0] cfg_out_addr;
  logic [AW-1:0] cfg_count;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          fir_start;
  logic          fir_done;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;
  logic          busy;
  logic          err;

  fir_stream_dma #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .go           (go),
    .cfg_in_addr  (cfg_in_addr),
    .cfg_out_addr (cfg_out_addr),
    .cfg_count    (cfg_count),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .fir_start    (fir_start),
    .fir_done     (fir_done),
    .m_valid      (m_valid),
    .m_data       (m_data),
    .m_ready      (m_ready),
    .busy         (busy),
    .err          (err)
  );

  // ---------------------------------------------------------- clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------ bench state
  int            n_tests;
  int            n_fail;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mem [0:1023];
  logic [DW-1:0] samp [64];

  int            cyc;
  int            job_in_base;
  int            job_out_base;
  int            job_count;
  int            eng_low_at;
  int            eng_delay;
  int            eng_t;
  logic          eng_busy;
  int            done_rise_cyc;

  int            ready_mode;
  int            job_seq;
  int            seen_seq;
  int            first_mv_cyc;
  int            err_cnt, we_cnt, start_cnt, busy_cnt, mv_cnt;
  logic          prev_stall;
  logic [DW-1:0] prev_data;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ------------------------------------- memory model + filter engine
  // Port A: write on mem_we, registered read. The engine doubles each loaded
  // sample into the result region and raises done eng_delay cycles after
  // fir_start; eng_low_at>0 keeps a stale high done for that many cycles.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
    if (fir_start) begin
      eng_busy <= 1'b1;
      eng_t    <= 0;
      for (int k = 0; k < job_count; k++) begin
        mem[10'(job_out_base + k)] <= 8'(2 * int'(mem[10'(job_in_base + k)]));
      end
      if (eng_low_at == 0) fir_done <= 1'b0;
    end else if (eng_busy) begin
      eng_t <= eng_t + 1;
      if (eng_t + 1 == eng_low_at) fir_done <= 1'b0;
      if (eng_t + 1 == eng_delay) begin
        fir_done      <= 1'b1;
        eng_busy      <= 1'b0;
        done_rise_cyc <= cyc + 1;
      end
    end
  end

  // ------------------------------------------------- m_ready driver
  initial begin
    logic [3:0] ready_pat;
    int rp;
    ready_pat = 4'b1001;
    rp = 0;
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: m_ready = 1'b1;
        1: begin
          m_ready = ready_pat[rp];
          rp = (rp + 1) % 4;
        end
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ------------------------------------------- monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall) begin
        check_eq("stall_valid_held", 32'(m_valid), 32'd1);
        check_eq("stall_data_held", 32'(m_data), 32'(prev_data));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) check_eq("extra_beat", 32'd1, 32'd0);
        else check_eq("m_data", 32'(m_data), 32'(exp_q.pop_front()));
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end else begin
      prev_stall = 1'b0;
    end
    if (err)       err_cnt++;
    if (mem_we)    we_cnt++;
    if (fir_start) start_cnt++;
    if (busy)      busy_cnt++;
    if (m_valid)   mv_cnt++;
    if (m_valid && (seen_seq != job_seq)) begin
      first_mv_cyc = cyc;
      seen_seq     = job_seq;
    end
  end

  // ------------------------------------------------- driver tasks
  task automatic run_job(input logic [AW-1:0] ib, input int cnt, input int rmode,
                         input bit stale, input bit gaps, input bit go_in_unload);
    logic [AW-1:0] ob;
    int k, to, s0;
    bit acc;
    ob = ib + 10'd512;
    job_in_base  = int'(ib);
    job_out_base = int'(ob);
    job_count    = cnt;
    eng_low_at   = stale ? 10 : 0;
    eng_delay    = 20;
    ready_mode   = rmode;
    for (int i = 0; i < cnt; i++) exp_q.push_back(8'(2 * int'($signed(samp[i]))));
    s0 = start_cnt;
    job_seq++;

    @(posedge clk); #1;
    cfg_in_addr = ib; cfg_out_addr = ob; cfg_count = AW'(cnt); go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    cfg_in_addr = AW'($urandom); cfg_out_addr = AW'($urandom); cfg_count = AW'($urandom);
    check_eq("busy_after_go", 32'(busy), 32'd1);

    k = 0; to = 0;
    while (k < cnt && to < 5000) begin
      s_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_data  = samp[k];
      @(negedge clk);
      acc = s_valid && s_ready;
      @(posedge clk); #1;
      if (acc) k++;
      to++;
    end
    s_valid = 1'b0;
    check_eq("load_complete", 32'(k), 32'(cnt));

    if (go_in_unload) begin
      to = 0;
      while (!m_valid && to < 500) begin @(negedge clk); to++; end
      check_eq("unload_reached", 32'(m_valid), 32'd1);
      @(posedge clk); #1;
      cfg_in_addr = 10'd5; cfg_out_addr = 10'd600; cfg_count = 10'd3; go = 1'b1;
      @(posedge clk); #1;
      go = 1'b0;
    end

    to = 0;
    while (busy && to < 3000) begin @(negedge clk); to++; end
    check_eq("busy_drops", 32'(busy), 32'd0);
    check_eq("beats_left_at_idle", 32'(exp_q.size()), 32'd0);
    repeat (4) @(negedge clk);
    check_eq("stays_idle", 32'(busy), 32'd0);
    check_eq("one_start_pulse", 32'(start_cnt - s0), 32'd1);
    check_eq("done_to_mvalid", 32'(first_mv_cyc - done_rise_cyc), 32'd2);
    for (int i = 0; i < cnt; i++)
      check_eq("loaded_word", 32'(mem[10'(int'(ib) + i)]), 32'(samp[i]));
    exp_q.delete();
  endtask

  // ------------------------------------------------- main sequence
  initial begin
    int e0, w0, s0, b0, mv0, rnd_ib, rnd_cnt;
    rst = 1'b1; go = 1'b0;
    cfg_in_addr = '0; cfg_out_addr = '0; cfg_count = '0;
    s_valid = 1'b0; s_data = '0;
    ready_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_s_ready", 32'(s_ready), 32'd0);
    check_eq("rst_mem_we", 32'(mem_we), 32'd0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_fir_start", 32'(fir_start), 32'd0);
    check_eq("rst_m_valid", 32'(m_valid), 32'd0);
    check_eq("rst_m_data", 32'(m_data), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    rst = 1'b0;

    // Basic job, free-flowing output.
    samp[0] = 8'd10; samp[1] = 8'd20; samp[2] = 8'd30; samp[3] = 8'd40;
    run_job(10'd0, 4, 0, 1'b0, 1'b0, 1'b0);
    // Same job with m_ready stalls.
    run_job(10'd0, 4, 1, 1'b0, 1'b0, 1'b0);

    // Zero-count job is rejected.
    e0 = err_cnt; w0 = we_cnt; s0 = start_cnt; b0 = busy_cnt;
    @(posedge clk); #1;
    cfg_count = '0; cfg_in_addr = 10'd7; go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("err_one_cycle", 32'(err_cnt - e0), 32'd1);
    check_eq("err_no_busy", 32'(busy_cnt - b0), 32'd0);
    check_eq("err_no_write", 32'(we_cnt - w0), 32'd0);
    check_eq("err_no_start", 32'(start_cnt - s0), 32'd0);

    // Stale done left high by the previous run.
    samp[0] = 8'd3; samp[1] = 8'd9; samp[2] = 8'd100; samp[3] = 8'd77; samp[4] = 8'd1;
    run_job(10'd40, 5, 0, 1'b1, 1'b0, 1'b0);

    // Address wrap with signed samples.
    samp[0] = 8'hFB; samp[1] = 8'hFF; samp[2] = 8'h00; samp[3] = 8'h7F;
    run_job(10'd1022, 4, 0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of LOAD.
    for (int i = 0; i < 6; i++) samp[i] = 8'($urandom);
    s0 = start_cnt; mv0 = mv_cnt;
    job_seq++;
    @(posedge clk); #1;
    cfg_in_addr = 10'd100; cfg_out_addr = 10'd612; cfg_count = 10'd6; go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    s_valid = 1'b1; s_data = samp[0];
    @(posedge clk); #1;
    s_data = samp[1];
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_s_ready", 32'(s_ready), 32'd0);
    check_eq("mid_rst_mem_we", 32'(mem_we), 32'd0);
    check_eq("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("mid_rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_m_valid", 32'(m_valid), 32'd0);
    s_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check_eq("abort_no_start", 32'(start_cnt - s0), 32'd0);
    check_eq("abort_no_output", 32'(mv_cnt - mv0), 32'd0);
    check_eq("abort_idle", 32'(busy), 32'd0);
    check_eq("abort_beat0", 32'(mem[100]), 32'(samp[0]));
    check_eq("abort_beat1", 32'(mem[101]), 32'(samp[1]));

    // Fresh job after reset, with go pulsed during UNLOAD.
    for (int i = 0; i < 8; i++) samp[i] = 8'($urandom);
    run_job(10'd200, 8, 1, 1'b0, 1'b0, 1'b1);

    // Random jobs.
    for (int n = 0; n < 8; n++) begin
      rnd_ib  = $urandom_range(0, 1023);
      rnd_cnt = $urandom_range(1, 24);
      for (int i = 0; i < rnd_cnt; i++) samp[i] = 8'($urandom);
      run_job(10'(rnd_ib), rnd_cnt, 2, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
